playback_seq_ctrl: RTL

Single-clock, parametrised successor to the per-channel RAM address controller. Plays a DATA_WIDTH-wide pattern from a synchronous RAM between programmable start and stop addresses, with an internal rate divider, finite or infinite loop count, circular address wrap and abort. It also supports a write mode with auto-incrementing address. It sits between the AXI-GPIO configuration registers and the pattern BRAM, and drives the channel output lanes.

---
 rtl/playback_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/playback_seq_ctrl.sv
// Pattern playback / write-address controller for one channel: reads a RAM window at a
// programmable rate with loop count and circular wrap, or generates auto-incrementing write addresses.
module playback_seq_ctrl #(
  parameter int unsigned N_ADDR_BITS = 20,
  parameter int unsigned MEM_DEPTH   = 1048576,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned N_LOOP_BITS = 16,
  parameter int unsigned DIV_BITS    = 16,
  parameter logic [DATA_WIDTH-1:0] IDLE_LEVEL = '0
) (
  input  logic                   s_axi_clk,
  input  logic                   s_axi_reset,
  input  logic                   cfg_wr,
  input  logic [N_ADDR_BITS-1:0] cfg_start_addr,
  input  logic [N_ADDR_BITS-1:0] cfg_stop_addr,
  input  logic [N_LOOP_BITS-1:0] cfg_loop_count,
  input  logic [DIV_BITS-1:0]    cfg_div,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic                   wr_strobe,
  output logic [N_ADDR_BITS-1:0] ram_addr,
  output logic                   ram_en,
  output logic                   wen,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  output logic [DATA_WIDTH-1:0]  ch_out,
  output logic                   busy,
  output logic                   playback_done,
  output logic [N_LOOP_BITS-1:0] loops_left
);

  localparam logic [N_ADDR_BITS-1:0] LAST_ADDR = N_ADDR_BITS'(MEM_DEPTH - 1);
  localparam logic [DIV_BITS-1:0]    MIN_DIV   = DIV_BITS'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_PRIME,
    S_PLAY,
    S_DONE
  } state_t;

  state_t                 state;
  logic [N_ADDR_BITS-1:0] cfg_start_q;
  logic [N_ADDR_BITS-1:0] cfg_stop_q;
  logic [N_LOOP_BITS-1:0] cfg_loop_q;
  logic [DIV_BITS-1:0]    cfg_div_q;
  logic                   start_q;
  logic [DIV_BITS-1:0]    div_cnt;
  logic                   last_word;

  logic                   start_edge;
  logic                   tick;
  logic                   cfg_open;
  logic [DIV_BITS-1:0]    period_m1;

  function automatic logic [N_ADDR_BITS-1:0] addr_inc(input logic [N_ADDR_BITS-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + N_ADDR_BITS'(1);
  endfunction

  assign start_edge = start & ~start_q;
  assign tick       = (div_cnt == '0);
  assign cfg_open   = (state == S_IDLE) || (state == S_DONE);
  assign period_m1  = (cfg_div_q < MIN_DIV) ? MIN_DIV : cfg_div_q;
  assign wen        = (state == S_WRITE) & wr_strobe;

  // Configuration registers; writes are only accepted between runs
  always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
    if (s_axi_reset) begin
      cfg_start_q <= '0;
      cfg_stop_q  <= LAST_ADDR;
      cfg_loop_q  <= N_LOOP_BITS'(1);
      cfg_div_q   <= MIN_DIV;
    end else if (cfg_wr && cfg_open) begin
      cfg_start_q <= cfg_start_addr;
      cfg_stop_q  <= cfg_stop_addr;
      cfg_loop_q  <= cfg_loop_count;
      cfg_div_q   <= cfg_div;
    end
  end

  always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
    if (s_axi_reset) start_q <= 1'b0;
    else             start_q <= start;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
    if (s_axi_reset) begin
      state         <= S_IDLE;
      ram_addr      <= '0;
      ram_en        <= 1'b0;
      ch_out        <= IDLE_LEVEL;
      busy          <= 1'b0;
      playback_done <= 1'b0;
      loops_left    <= '0;
      div_cnt       <= '0;
      last_word     <= 1'b0;
    end else begin
      ram_en <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        ram_addr      <= '0;
        ch_out        <= IDLE_LEVEL;
        busy          <= 1'b0;
        playback_done <= 1'b0;
        last_word     <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_edge) begin
              state         <= S_PRIME;
              ram_addr      <= cfg_start_q;
              ram_en        <= 1'b1;
              loops_left    <= cfg_loop_q;
              busy          <= 1'b1;
              playback_done <= 1'b0;
            end else if (mode) begin
              state         <= S_WRITE;
              ram_addr      <= cfg_start_q;
              playback_done <= 1'b0;
            end
          end
          S_WRITE: begin
            if (wr_strobe) ram_addr <= addr_inc(ram_addr);
            if (!mode)     state    <= S_IDLE;
          end
          S_PRIME: begin
            state     <= S_PLAY;
            div_cnt   <= '0;
            last_word <= 1'b0;
          end
          S_PLAY: begin
            if (tick) begin
              div_cnt <= period_m1;
              if (last_word) begin
                // One period after the final word has been presented
                state         <= S_DONE;
                ch_out        <= IDLE_LEVEL;
                busy          <= 1'b0;
                playback_done <= 1'b1;
                last_word     <= 1'b0;
              end else begin
                ch_out <= ram_dout;
                if (ram_addr != cfg_stop_q) begin
                  ram_addr <= addr_inc(ram_addr);
                  ram_en   <= 1'b1;
                end else if (loops_left == N_LOOP_BITS'(1)) begin
                  last_word <= 1'b1;
                end else begin
                  ram_addr <= cfg_start_q;
                  ram_en   <= 1'b1;
                  if (loops_left != '0) loops_left <= loops_left - N_LOOP_BITS'(1);
                end
              end
            end else begin
              div_cnt <= div_cnt - DIV_BITS'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
